// File: rtl/dcache_refill_engine.sv
// Data cache refill engine. On a miss it writes back the dirty victim block,
// then reads the missing block as 8 beats. It returns the assembled block to
// the cache with a one-cycle block write enable. The memory stage stays
// stalled until the refill is complete.
module dcache_refill_engine #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_mem_access,
  input  logic                   i_dcache_hit,
  input  logic                   i_dcache_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_victim_block,
  output logic                   o_stall,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic                   o_mem_req_write,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  output logic                   o_mem_wvalid,
  input  logic                   i_mem_wready,
  output logic [DATA_WIDTH-1:0]  o_mem_wdata,
  output logic                   o_mem_wlast,
  input  logic                   i_mem_bvalid,
  output logic                   o_mem_bready,
  input  logic                   i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]  i_mem_rdata,
  output logic                   o_mem_rready
);

  localparam int unsigned BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWbReq,
    StWbData,
    StWbResp,
    StRdReq,
    StRdData,
    StFill
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  addr_wb_q;
  logic [BLOCK_WIDTH-1:0] victim_q;
  logic [BLOCK_WIDTH-1:0] fill_q;
  logic                   miss;

  assign miss = i_mem_access & ~i_dcache_hit;

  // Refill sequencer: state, beat counter, latched request and fill buffer.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      addr_wb_q <= '0;
      victim_q  <= '0;
      fill_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss) begin
            addr_q    <= i_addr & ALIGN_MASK;
            addr_wb_q <= i_addr_wb & ALIGN_MASK;
            victim_q  <= i_victim_block;
            cnt_q     <= '0;
            state_q   <= i_dcache_dirty ? StWbReq : StRdReq;
          end
        end
        StWbReq: begin
          if (i_mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= StWbData;
          end
        end
        StWbData: begin
          if (i_mem_wready) begin
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              state_q <= StWbResp;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StWbResp: begin
          // Write response status is deliberately ignored.
          if (i_mem_bvalid) state_q <= StRdReq;
        end
        StRdReq: begin
          if (i_mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= StRdData;
          end
        end
        StRdData: begin
          // The beat counter alone decides when the block is complete.
          if (i_mem_rvalid) begin
            fill_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= i_mem_rdata;
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              state_q <= StFill;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StFill: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decoded from registered state. The stall also covers the miss
  // cycle itself, and reset forces it low.
  always_comb begin
    o_stall         = ~i_arst & (miss | (state_q != StIdle));
    o_block_we      = (state_q == StFill);
    o_data_block    = fill_q;
    o_mem_req_valid = (state_q == StWbReq) | (state_q == StRdReq);
    o_mem_req_write = (state_q == StWbReq);
    o_mem_req_addr  = '0;
    if (state_q == StWbReq) o_mem_req_addr = addr_wb_q;
    if (state_q == StRdReq) o_mem_req_addr = addr_q;
    o_mem_wvalid    = (state_q == StWbData);
    o_mem_wdata     = victim_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
    o_mem_wlast     = (state_q == StWbData) & (cnt_q == LAST_BEAT);
    o_mem_bready    = (state_q == StWbResp);
    o_mem_rready    = (state_q == StRdData);
  end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Directed bench for dcache_refill_engine: a cycle table for the clean miss,
// then hand sequences for writeback, backpressure, read gaps and reset.
module tb_dcache_refill_engine;

  logic         i_clk = 1'b0;
  logic         i_arst;
  logic         i_mem_access, i_dcache_hit, i_dcache_dirty;
  logic [63:0]  i_addr, i_addr_wb;
  logic [511:0] i_victim_block;
  logic         o_stall, o_block_we;
  logic [511:0] o_data_block;
  logic         o_mem_req_valid, i_mem_req_ready, o_mem_req_write;
  logic [63:0]  o_mem_req_addr;
  logic         o_mem_wvalid, i_mem_wready, o_mem_wlast;
  logic [63:0]  o_mem_wdata;
  logic         i_mem_bvalid, o_mem_bready;
  logic         i_mem_rvalid, o_mem_rready;
  logic [63:0]  i_mem_rdata;

  dcache_refill_engine dut (
    .i_clk           (i_clk),
    .i_arst          (i_arst),
    .i_mem_access    (i_mem_access),
    .i_dcache_hit    (i_dcache_hit),
    .i_dcache_dirty  (i_dcache_dirty),
    .i_addr          (i_addr),
    .i_addr_wb       (i_addr_wb),
    .i_victim_block  (i_victim_block),
    .o_stall         (o_stall),
    .o_block_we      (o_block_we),
    .o_data_block    (o_data_block),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_write (o_mem_req_write),
    .o_mem_req_addr  (o_mem_req_addr),
    .o_mem_wvalid    (o_mem_wvalid),
    .i_mem_wready    (i_mem_wready),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wlast     (o_mem_wlast),
    .i_mem_bvalid    (i_mem_bvalid),
    .o_mem_bready    (o_mem_bready),
    .i_mem_rvalid    (i_mem_rvalid),
    .i_mem_rdata     (i_mem_rdata),
    .o_mem_rready    (o_mem_rready)
  );

  always #5 i_clk = ~i_clk;

  // Control outputs packed {stall, block_we, req_valid, req_write, wvalid, bready, rready}.
  localparam logic [6:0] O_ST = 7'b1000000;
  localparam logic [6:0] O_WE = 7'b0100000;
  localparam logic [6:0] O_RV = 7'b0010000;
  localparam logic [6:0] O_RW = 7'b0001000;
  localparam logic [6:0] O_WV = 7'b0000100;
  localparam logic [6:0] O_BR = 7'b0000010;
  localparam logic [6:0] O_RR = 7'b0000001;

  logic [6:0] outs;
  assign outs = {o_stall, o_block_we, o_mem_req_valid, o_mem_req_write,
                 o_mem_wvalid, o_mem_bready, o_mem_rready};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] blk_of(input logic [63:0] base);
    logic [511:0] b;
    for (int k = 0; k < 8; k++) b[k*64 +: 64] = base + 64'(k);
    return b;
  endfunction

  // Zero-wait 8-beat read burst followed by the FILL cycle check.
  task automatic read_and_fill(input string name, input logic [63:0] base);
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = base + 64'(k);
      #1 chk($sformatf("%s rd%0d outs", name, k), 64'(outs), 64'(O_ST | O_RR));
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    #1 chk($sformatf("%s fill outs", name), 64'(outs), 64'(O_ST | O_WE));
    chk_blk($sformatf("%s fill block", name), o_data_block, blk_of(base));
  endtask

  // One idle cycle with a hit: no stall, no traffic.
  task automatic idle_hit(input string name);
    @(negedge i_clk);
    i_mem_access = 1'b1;
    i_dcache_hit = 1'b1;
    #1 chk($sformatf("%s idle hit", name), 64'(outs), 64'h0);
  endtask

  typedef struct {
    logic        acc;
    logic        hit;
    logic        rvalid;
    logic [63:0] rdata;
    logic [6:0]  exp_outs;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int accepted;
    logic [3:0] wpat;

    // Clean miss at 0x1048, always-ready memory, beat k carries k.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'h0, O_ST, 64'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 64'h0, O_ST | O_RV, 64'h1040};
    for (int k = 0; k < 8; k++) tbl[2+k] = '{1'b0, 1'b0, 1'b1, 64'(k), O_ST | O_RR, 64'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 64'h0, O_ST | O_WE, 64'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 64'h0, 7'b0, 64'h0};

    i_arst = 1'b1;
    i_mem_access = 1'b0; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b0;
    i_addr = '0; i_addr_wb = '0; i_victim_block = '0;
    i_mem_req_ready = 1'b0; i_mem_wready = 1'b0; i_mem_bvalid = 1'b0;
    i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    #12;
    chk("reset outs", 64'(outs), 64'h0);
    chk_blk("reset block", o_data_block, '0);
    chk("reset addr", o_mem_req_addr, 64'h0);
    @(negedge i_clk);
    i_arst = 1'b0;

    // Hits produce no stall and no traffic.
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      i_mem_access = 1'b1;
      i_dcache_hit = 1'b1;
      #1 chk($sformatf("hit%0d outs", c), 64'(outs), 64'h0);
    end

    // Table-driven clean miss.
    i_addr = 64'h1048;
    i_mem_req_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      @(negedge i_clk);
      i_mem_access = tbl[r].acc;
      i_dcache_hit = tbl[r].hit;
      i_mem_rvalid = tbl[r].rvalid;
      i_mem_rdata  = tbl[r].rdata;
      #1 chk($sformatf("tbl%0d outs", r), 64'(outs), 64'(tbl[r].exp_outs));
      if ((tbl[r].exp_outs & O_RV) != 0)
        chk($sformatf("tbl%0d addr", r), o_mem_req_addr, tbl[r].exp_addr);
      if ((tbl[r].exp_outs & O_WE) != 0)
        chk_blk("tbl fill block", o_data_block, blk_of(64'h0));
    end

    // Dirty miss: write burst to 0x2000, read only after bvalid.
    @(negedge i_clk);
    i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b1;
    i_addr = 64'h3008; i_addr_wb = 64'h2000; i_victim_block = blk_of(64'hA0);
    i_mem_req_ready = 1'b1; i_mem_wready = 1'b1; i_mem_rvalid = 1'b0;
    #1 chk("dirty miss outs", 64'(outs), 64'(O_ST));
    @(negedge i_clk);
    i_mem_access = 1'b0; i_dcache_dirty = 1'b0; i_victim_block = '0;
    #1 chk("dirty wbreq outs", 64'(outs), 64'(O_ST | O_RV | O_RW));
    chk("dirty wbreq addr", o_mem_req_addr, 64'h2000);
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      #1 chk($sformatf("dirty wb%0d outs", k), 64'(outs), 64'(O_ST | O_WV));
      chk($sformatf("dirty wb%0d data", k), o_mem_wdata, 64'hA0 + 64'(k));
      chk($sformatf("dirty wb%0d last", k), 64'(o_mem_wlast), (k == 7) ? 64'h1 : 64'h0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      #1 chk($sformatf("dirty resp wait%0d", c), 64'(outs), 64'(O_ST | O_BR));
    end
    @(negedge i_clk);
    i_mem_bvalid = 1'b1;
    #1 chk("dirty resp outs", 64'(outs), 64'(O_ST | O_BR));
    @(negedge i_clk);
    i_mem_bvalid = 1'b0;
    #1 chk("dirty rdreq outs", 64'(outs), 64'(O_ST | O_RV));
    chk("dirty rdreq addr", o_mem_req_addr, 64'h3000);
    read_and_fill("dirty", 64'h55);
    idle_hit("dirty");

    // Backpressure: request accepted after 3 cycles, wready 1,0,0,1,...
    @(negedge i_clk);
    i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b1;
    i_addr = 64'h8010; i_addr_wb = 64'h6057; i_victim_block = blk_of(64'hB0);
    i_mem_req_ready = 1'b0; i_mem_wready = 1'b0;
    #1 chk("bp miss outs", 64'(outs), 64'(O_ST));
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      i_mem_access = 1'b0;
      i_mem_req_ready = (c == 3);
      #1 chk($sformatf("bp wbreq%0d outs", c), 64'(outs), 64'(O_ST | O_RV | O_RW));
      chk($sformatf("bp wbreq%0d addr", c), o_mem_req_addr, 64'h6040);
    end
    wpat = 4'b1001;
    accepted = 0;
    for (int c = 0; c < 40 && accepted < 8; c++) begin
      @(negedge i_clk);
      i_mem_wready = wpat[c % 4];
      #1 chk($sformatf("bp wb c%0d outs", c), 64'(outs), 64'(O_ST | O_WV));
      chk($sformatf("bp wb c%0d data", c), o_mem_wdata, 64'hB0 + 64'(accepted));
      chk($sformatf("bp wb c%0d last", c), 64'(o_mem_wlast), (accepted == 7) ? 64'h1 : 64'h0);
      if (i_mem_wready) accepted++;
    end
    chk("bp beats accepted", 64'(accepted), 64'd8);
    @(negedge i_clk);
    i_mem_wready = 1'b0; i_mem_bvalid = 1'b1;
    #1 chk("bp resp outs", 64'(outs), 64'(O_ST | O_BR));
    @(negedge i_clk);
    i_mem_bvalid = 1'b0; i_mem_req_ready = 1'b1;
    #1 chk("bp rdreq addr", o_mem_req_addr, 64'h8000);
    read_and_fill("bp", 64'hC0);
    idle_hit("bp");

    // Read gaps: rvalid every other cycle, fill 16 cycles after RD_DATA entry.
    @(negedge i_clk);
    i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_dcache_dirty = 1'b0; i_addr = 64'h7000;
    #1 chk("gap miss outs", 64'(outs), 64'(O_ST));
    @(negedge i_clk);
    i_mem_access = 1'b0;
    #1 chk("gap rdreq outs", 64'(outs), 64'(O_ST | O_RV));
    for (int i = 0; i < 16; i++) begin
      @(negedge i_clk);
      i_mem_rvalid = (i % 2 == 1);
      i_mem_rdata  = 64'h300 + 64'(i / 2);
      #1 chk($sformatf("gap c%0d outs", i), 64'(outs), 64'(O_ST | O_RR));
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    #1 chk("gap fill outs", 64'(outs), 64'(O_ST | O_WE));
    chk_blk("gap fill block", o_data_block, blk_of(64'h300));
    idle_hit("gap");

    // Reset after 4 read beats, then a fresh clean miss.
    @(negedge i_clk);
    i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_addr = 64'h4000;
    @(negedge i_clk);
    i_mem_access = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 64'hF0 + 64'(k);
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    i_arst = 1'b1;
    #1 chk("rst mid outs", 64'(outs), 64'h0);
    chk_blk("rst mid block", o_data_block, '0);
    chk("rst mid addr", o_mem_req_addr, 64'h0);
    @(negedge i_clk);
    i_arst = 1'b0;
    i_mem_access = 1'b1; i_dcache_hit = 1'b0; i_addr = 64'h50BF;
    #1 chk("rst miss outs", 64'(outs), 64'(O_ST));
    @(negedge i_clk);
    i_mem_access = 1'b0;
    #1 chk("rst rdreq outs", 64'(outs), 64'(O_ST | O_RV));
    chk("rst rdreq addr", o_mem_req_addr, 64'h5080);
    read_and_fill("rst", 64'h200);
    idle_hit("rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
